eeprom_access_arbiter: RTL and testbench
========================================

// Module: eeprom_access_arbiter
// PURPOSE
//  Shares one serial EEPROM read/write engine between two requesters (port 0, port 1).
//  Round-robin arbitration, one transaction in flight. Drives engine WR/RD/ADDR/DATA and
//  waits for the engine's one-transaction ACK. Returns read data and done/err per port.
//  Watchdog aborts a hung transaction. Sits between system masters and the EEPROM engine.
// PARAMETERS
//  ADDR_W   11    EEPROM byte address width (bits [10:8] go into the engine control byte)
//  DATA_W   8     data byte width
//  TMO_CYC  4095  max CLK cycles in WAIT_ACK before abort; must be >=2 and < 2**TMO_W
//  TMO_W    12    watchdog counter width
// PORTS
//  CLK          in   1       system clock, all logic on posedge
//  RESET        in   1       synchronous, active-high reset
//  req_i[p]     in   1x2     p=0,1: request, held high until done_o[p]/err_o[p]
//  we_i[p]      in   1x2     1=write, 0=read; stable while req_i[p] high
//  addr_i[p]    in   ADDR_Wx2  byte address; stable while req_i[p] high
//  wdata_i[p]   in   DATA_Wx2  write byte; stable while req_i[p] high
//  gnt_o[p]     out  1x2     high while port p owns the engine (ISSUE..DONE)
//  done_o[p]    out  1x2     1-cycle pulse: transaction of port p completed OK
//  err_o[p]     out  1x2     1-cycle pulse: transaction of port p timed out
//  rdata_o      out  DATA_W  read byte, valid on done_o pulse of a read; held until next read done
//  eng_wr       out  1       engine WR strobe
//  eng_rd       out  1       engine RD strobe
//  eng_addr     out  ADDR_W  engine address
//  eng_dout     out  DATA_W  byte to engine parallel bus
//  eng_doe      out  1       1=drive eng_dout onto engine DATA bus (write txn only)
//  eng_din      in   DATA_W  engine DATA bus as seen by arbiter
//  eng_ack      in   1       engine end-of-transaction ACK (level; rising edge used)
//  eng_reset    out  1       engine reset request; 1-cycle pulse on timeout
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr_last=1 (port 0 wins first tie), watchdog 0.
//  - FSM states IDLE -> ISSUE -> WAIT_ACK -> DONE -> IDLE; all registered.
//  - IDLE: if any req_i, pick port: single requester wins; both -> port != rr_last.
//    Capture we/addr/wdata of winner into regs, set gnt_o[p], go ISSUE. No req: stay.
//  - ISSUE (1 cycle): eng_wr=we, eng_rd=~we (exactly one high), eng_addr/eng_dout from regs,
//    eng_doe=we. Next WAIT_ACK. Strobes are single-cycle pulses.
//  - WAIT_ACK: eng_addr/eng_dout/eng_doe held; eng_wr=eng_rd=0; watchdog counts each cycle.
//    eng_ack rising (ack_q=0, eng_ack=1): if read, rdata_o<=eng_din same edge; -> DONE(ok).
//    watchdog reaches TMO_CYC with no ack: eng_reset pulse, -> DONE(err). Ack and timeout
//    same cycle: ack wins.
//  - ACK already high entering WAIT_ACK is ignored until seen low (edge-detected).
//  - DONE (1 cycle): done_o[p] or err_o[p] pulses; gnt_o[p] drops at exit; eng_doe=0;
//    rr_last<=p; watchdog cleared; -> IDLE. Grant latency req->ISSUE = 1 cycle from IDLE.
//  - Minimum txn: IDLE,ISSUE,WAIT_ACK(>=1),DONE = 4 cycles; back-to-back gap 1 IDLE cycle.
//  - req_i dropped by master mid-transaction: transaction still completes; pulse still issued.
//  - Capture regs change only in IDLE; input changes during grant have no effect.
//  - RESET mid-transaction: immediate return to reset values; no done/err pulse.
//  - gnt_o one-hot or zero; done_o/err_o never both high; never high for non-granted port.
// TESTING
//  1 Port0 write addr=0x3A5 data=0x5C, ACK after 20 cycles -> one eng_wr pulse, eng_addr=0x3A5,
//    eng_dout=0x5C, eng_doe=1, done_o[0] 1 cycle after ACK edge, err_o=0.
//  2 Port1 read addr=0x010, eng_din=0xA7 at ACK -> eng_rd pulse, rdata_o=0xA7 with done_o[1].
//  3 Both request continuously from reset -> grants alternate 0,1,0,1; 4 txns, 4 done pulses.
//  4 No ACK with TMO_CYC=16 -> err_o pulse and eng_reset pulse 16 cycles into WAIT_ACK; next
//    request served normally.
//  5 eng_ack stuck high entering WAIT_ACK, falls at +3, rises at +8 -> done on +8 edge only.
//  6 RESET asserted in WAIT_ACK -> all outputs 0 next cycle, no done/err, port0 wins next tie.

Source files
------------

// File: rtl/eeprom_access_arbiter_if.sv
// Requester-side bundle of the EEPROM access arbiter: two ports of
// request/attributes in, grant/completion/read data out.
interface eeprom_access_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic [1:0]             req_i;
  logic [1:0]             we_i;
  logic [1:0][ADDR_W-1:0] addr_i;
  logic [1:0][DATA_W-1:0] wdata_i;
  logic [1:0]             gnt_o;
  logic [1:0]             done_o;
  logic [1:0]             err_o;
  logic [DATA_W-1:0]      rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, done_o, err_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, done_o, err_o, rdata_o
  );
endinterface

// File: rtl/eeprom_access_arbiter.sv
// Round-robin share of one serial EEPROM engine between two requesters,
// one transaction in flight, ACK edge detect and hang watchdog.
module eeprom_access_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int TMO_CYC = 4095,
  parameter int TMO_W   = 12
) (
  input  logic                   CLK,
  input  logic                   RESET,
  eeprom_access_arbiter_if.slave bus,
  output logic                   eng_wr,
  output logic                   eng_rd,
  output logic [ADDR_W-1:0]      eng_addr,
  output logic [DATA_W-1:0]      eng_dout,
  output logic                   eng_doe,
  input  logic [DATA_W-1:0]      eng_din,
  input  logic                   eng_ack,
  output logic                   eng_reset
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              rr_last_q, rr_last_d;
  logic              ack_q;
  logic [TMO_W-1:0]  wdog_q, wdog_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              doe_q, doe_d;
  logic              rst_q, rst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              pick;
  logic              ack_rise;

  // Tie goes to the port that did not complete last.
  assign pick     = (&bus.req_i) ? ~rr_last_q : bus.req_i[1];
  assign ack_rise = eng_ack & ~ack_q;

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    we_d      = we_q;
    rr_last_d = rr_last_q;
    wdog_d    = wdog_q;
    gnt_d     = gnt_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    doe_d     = doe_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    rst_d     = 1'b0;
    done_d    = '0;
    err_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req_i) begin
          state_d = S_ISSUE;
          port_d  = pick;
          we_d    = bus.we_i[pick];
          addr_d  = bus.addr_i[pick];
          dout_d  = bus.wdata_i[pick];
          gnt_d   = pick ? 2'b10 : 2'b01;
          wr_d    = bus.we_i[pick];
          rd_d    = ~bus.we_i[pick];
          doe_d   = bus.we_i[pick];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wdog_d  = '0;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (ack_rise) begin
          state_d        = S_DONE;
          done_d[port_q] = 1'b1;
          doe_d          = 1'b0;
          if (!we_q) rdata_d = eng_din;
        end else if (wdog_q == TMO_LAST) begin
          state_d       = S_DONE;
          err_d[port_q] = 1'b1;
          rst_d         = 1'b1;
          doe_d         = 1'b0;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        gnt_d     = '0;
        rr_last_d = port_q;
        wdog_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      rr_last_q <= 1'b1;
      ack_q     <= 1'b0;
      wdog_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      doe_q     <= 1'b0;
      rst_q     <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      we_q      <= we_d;
      rr_last_q <= rr_last_d;
      ack_q     <= eng_ack;
      wdog_q    <= wdog_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      doe_q     <= doe_d;
      rst_q     <= rst_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata_q;
  assign eng_wr      = wr_q;
  assign eng_rd      = rd_q;
  assign eng_addr    = addr_q;
  assign eng_dout    = dout_q;
  assign eng_doe     = doe_q;
  assign eng_reset   = rst_q;

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Scoreboard bench for eeprom_access_arbiter: main instance with a long
// watchdog, second instance with TMO_CYC=16 for the hang/abort case.
module tb_eeprom_access_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;

  typedef struct packed {
    logic          p;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
  } iss_t;

  typedef struct packed {
    logic          p;
    logic          err;
    logic          rd;
    logic [DW-1:0] rdata;
  } cmp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  eeprom_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  eeprom_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  logic          eng_wr, eng_rd, eng_doe, eng_reset, eng_ack;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_dout, eng_din;
  logic          b_eng_wr, b_eng_rd, b_eng_doe, b_eng_reset, b_eng_ack;
  logic [AW-1:0] b_eng_addr;
  logic [DW-1:0] b_eng_dout, b_eng_din;

  eeprom_access_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TMO_CYC(64), .TMO_W(12)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus),
    .eng_wr(eng_wr), .eng_rd(eng_rd), .eng_addr(eng_addr),
    .eng_dout(eng_dout), .eng_doe(eng_doe), .eng_din(eng_din),
    .eng_ack(eng_ack), .eng_reset(eng_reset)
  );

  eeprom_access_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TMO_CYC(16), .TMO_W(12)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(bus_b),
    .eng_wr(b_eng_wr), .eng_rd(b_eng_rd), .eng_addr(b_eng_addr),
    .eng_dout(b_eng_dout), .eng_doe(b_eng_doe), .eng_din(b_eng_din),
    .eng_ack(b_eng_ack), .eng_reset(b_eng_reset)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;
  int ack_cyc = 0;
  iss_t iss_q[$];
  cmp_t cmp_q[$];
  iss_t ie;
  cmp_t ce;
  logic [1:0] pm;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_iss(input logic p, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    iss_t e;
    e.p = p; e.wr = wr; e.addr = a; e.dout = d;
    iss_q.push_back(e);
  endtask

  task automatic exp_cmp(input logic p, input logic er,
                         input logic rd, input logic [DW-1:0] d);
    cmp_t e;
    e.p = p; e.err = er; e.rd = rd; e.rdata = d;
    cmp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      if (eng_wr || eng_rd) begin
        if (iss_q.size() == 0) begin
          check("iss_unexp", {30'b0, eng_wr, eng_rd}, 0);
        end else begin
          ie = iss_q.pop_front();
          pm = ie.p ? 2'b10 : 2'b01;
          check("iss_wr", eng_wr, ie.wr);
          check("iss_rd", eng_rd, !ie.wr);
          check("iss_addr", eng_addr, ie.addr);
          check("iss_doe", eng_doe, ie.wr);
          check("iss_gnt", bus.gnt_o, pm);
          if (ie.wr) check("iss_dout", eng_dout, ie.dout);
        end
      end
      if (|(bus.done_o | bus.err_o)) begin
        if (|bus.done_o) n_done++;
        if (cmp_q.size() == 0) begin
          check("rsp_unexp", {bus.done_o, bus.err_o}, 0);
        end else begin
          ce = cmp_q.pop_front();
          pm = ce.p ? 2'b10 : 2'b01;
          check("rsp_done", bus.done_o, ce.err ? 2'b00 : pm);
          check("rsp_err", bus.err_o, ce.err ? pm : 2'b00);
          check("rsp_gnt", bus.gnt_o, pm);
          check("rsp_doe", eng_doe, 0);
          if (ce.rd) check("rsp_rdata", bus.rdata_o, ce.rdata);
        end
      end
    end
  end

  task automatic wait_iss(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (!ok) begin
        @(negedge CLK);
        ok = eng_wr | eng_rd;
      end
    end
    if (!ok) check("iss_tmo", 0, 1);
  endtask

  task automatic wait_resp(input logic [1:0] m, input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (!ok) begin
        @(negedge CLK);
        ok = |((bus.done_o | bus.err_o) & m);
      end
    end
    if (!ok) check("resp_tmo", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n_tmo;
    int n0;
    bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    bus_b.req_i = '0; bus_b.we_i = '0;
    bus_b.addr_i = '0; bus_b.wdata_i = '0;
    eng_ack = 1'b0; eng_din = '0;
    b_eng_ack = 1'b0; b_eng_din = '0;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rst_gnt", bus.gnt_o, 0);
    check("rst_pulse", {bus.done_o, bus.err_o}, 0);
    check("rst_rdata", bus.rdata_o, 0);
    check("rst_eng", {eng_wr, eng_rd, eng_doe, eng_reset}, 0);
    check("rst_eng_bus", {eng_addr, eng_dout}, 0);
    check("rst_b_eng", {b_eng_wr, b_eng_rd, b_eng_reset}, 0);

    // write from port 0, ACK 20 cycles after the strobe
    exp_iss(1'b0, 1'b1, 11'h3A5, 8'h5C);
    exp_cmp(1'b0, 1'b0, 1'b0, 8'h00);
    bus.we_i[0] = 1'b1; bus.addr_i[0] = 11'h3A5;
    bus.wdata_i[0] = 8'h5C; bus.req_i[0] = 1'b1;
    wait_iss(8);
    repeat (20) @(posedge CLK);
    #1;
    check("t1_doe_wait", eng_doe, 1);
    check("t1_wr_low", eng_wr, 0);
    check("t1_addr_hold", eng_addr, 11'h3A5);
    eng_ack = 1'b1; ack_cyc = cyc;
    wait_resp(2'b01, 8);
    check("t1_lat", cyc - ack_cyc, 1);
    check("t1_rdata_hold", bus.rdata_o, 0);
    @(posedge CLK); #1 bus.req_i[0] = 1'b0; eng_ack = 1'b0;
    @(negedge CLK);
    check("t1_gnt_drop", bus.gnt_o, 0);
    check("t1_doe_drop", eng_doe, 0);

    // read from port 1
    exp_iss(1'b1, 1'b0, 11'h010, 8'h00);
    exp_cmp(1'b1, 1'b0, 1'b1, 8'hA7);
    bus.we_i[1] = 1'b0; bus.addr_i[1] = 11'h010; bus.req_i[1] = 1'b1;
    wait_iss(8);
    repeat (6) @(posedge CLK);
    #1 eng_din = 8'hA7; eng_ack = 1'b1;
    wait_resp(2'b10, 8);
    @(posedge CLK); #1 bus.req_i[1] = 1'b0; eng_ack = 1'b0; eng_din = '0;
    @(negedge CLK);
    check("t2_rdata_hold", bus.rdata_o, 8'hA7);

    // both ports requesting from reset: grants alternate 0,1,0,1
    do_reset();
    bus.we_i[0] = 1'b1; bus.addr_i[0] = 11'h100; bus.wdata_i[0] = 8'h11;
    bus.we_i[1] = 1'b0; bus.addr_i[1] = 11'h222;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        exp_iss(1'b0, 1'b1, 11'h100, 8'h11);
        exp_cmp(1'b0, 1'b0, 1'b0, 8'h00);
      end else begin
        exp_iss(1'b1, 1'b0, 11'h222, 8'h00);
        exp_cmp(1'b1, 1'b0, 1'b1, 8'(8'h40 + k));
      end
    end
    n0 = n_done;
    bus.req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_iss(8);
      repeat (k + 1) @(posedge CLK);
      #1 eng_din = 8'(8'h40 + k); eng_ack = 1'b1;
      wait_resp(2'b11, 8);
      @(posedge CLK); #1 eng_ack = 1'b0;
      if (k == 3) bus.req_i = 2'b00;
    end
    repeat (2) @(negedge CLK);
    check("t3_ndone", n_done - n0, 4);

    // ACK stuck high into WAIT_ACK: falls at +3, rises at +8
    exp_iss(1'b0, 1'b0, 11'h055, 8'h00);
    exp_cmp(1'b0, 1'b0, 1'b1, 8'h3C);
    eng_ack = 1'b1;
    bus.we_i[0] = 1'b0; bus.addr_i[0] = 11'h055; bus.req_i[0] = 1'b1;
    wait_iss(8);
    @(posedge CLK); #1;
    repeat (3) @(posedge CLK);
    #1 eng_ack = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("t5_no_early", {bus.done_o, bus.gnt_o}, 4'b0001);
    eng_din = 8'h3C; eng_ack = 1'b1; ack_cyc = cyc;
    wait_resp(2'b01, 8);
    check("t5_lat", cyc - ack_cyc, 1);
    @(posedge CLK); #1 bus.req_i[0] = 1'b0; eng_ack = 1'b0;

    // reset in WAIT_ACK; port 0 then wins a tie again
    exp_iss(1'b1, 1'b1, 11'h2AA, 8'h99);
    bus.we_i[1] = 1'b1; bus.addr_i[1] = 11'h2AA;
    bus.wdata_i[1] = 8'h99; bus.req_i[1] = 1'b1;
    wait_iss(8);
    repeat (4) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1 bus.req_i[1] = 1'b0;
    @(negedge CLK);
    check("t6_gnt", bus.gnt_o, 0);
    check("t6_pulse", {bus.done_o, bus.err_o}, 0);
    check("t6_rdata", bus.rdata_o, 0);
    check("t6_eng", {eng_wr, eng_rd, eng_doe, eng_reset}, 0);
    check("t6_eng_bus", {eng_addr, eng_dout}, 0);
    @(posedge CLK); #1 RESET = 1'b0;
    exp_iss(1'b0, 1'b0, 11'h001, 8'h00);
    exp_cmp(1'b0, 1'b0, 1'b1, 8'h5A);
    bus.we_i[0] = 1'b0; bus.addr_i[0] = 11'h001;
    bus.req_i = 2'b11;
    wait_iss(8);
    repeat (2) @(posedge CLK);
    #1 eng_din = 8'h5A; eng_ack = 1'b1;
    wait_resp(2'b01, 8);
    @(posedge CLK); #1 bus.req_i = 2'b00; eng_ack = 1'b0;
    repeat (3) @(negedge CLK);

    // no ACK on the TMO_CYC=16 instance: abort 16 cycles into WAIT_ACK
    bus_b.we_i[1] = 1'b0; bus_b.addr_i[1] = 11'h7FF; bus_b.req_i[1] = 1'b1;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (!ok) begin
        @(negedge CLK);
        ok = b_eng_rd;
      end
    end
    check("t4_iss", ok, 1);
    check("t4_addr", b_eng_addr, 11'h7FF);
    n_tmo = -1;
    for (int n = 0; n < 40; n++) begin
      if (n_tmo < 0) begin
        @(negedge CLK);
        if (|(bus_b.err_o | bus_b.done_o)) begin
          n_tmo = n;
          check("t4_rst", b_eng_reset, 1);
          check("t4_err", bus_b.err_o, 2'b10);
          check("t4_done", bus_b.done_o, 0);
        end
      end
    end
    check("t4_tmo_cyc", n_tmo, 16);
    @(posedge CLK); #1 bus_b.req_i[1] = 1'b0;
    @(negedge CLK);
    check("t4_pulse", {b_eng_reset, bus_b.err_o, bus_b.gnt_o}, 0);
    bus_b.we_i[0] = 1'b1; bus_b.addr_i[0] = 11'h004;
    bus_b.wdata_i[0] = 8'h77; bus_b.req_i[0] = 1'b1;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (!ok) begin
        @(negedge CLK);
        ok = b_eng_wr;
      end
    end
    check("t4_next_iss", ok, 1);
    check("t4_next_bus", {b_eng_addr, b_eng_dout}, {11'h004, 8'h77});
    repeat (3) @(posedge CLK);
    #1 b_eng_ack = 1'b1;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (!ok) begin
        @(negedge CLK);
        ok = |(bus_b.done_o | bus_b.err_o);
      end
    end
    check("t4_next_resp", ok, 1);
    check("t4_next_done", {bus_b.done_o, bus_b.err_o}, 4'b0100);
    @(posedge CLK); #1 bus_b.req_i[0] = 1'b0; b_eng_ack = 1'b0;
    repeat (2) @(negedge CLK);

    check("sb_empty", iss_q.size() + cmp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
